// File: rtl/imem_pipelined_pkg.sv
// Shared RV32 fetch definitions: data width, the canonical NOP and the fetch response record.
package imem_pipelined_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } fetch_resp_t;

endpackage

// File: rtl/imem_pipelined_if.sv
// Fetch-side bus between the PC/hazard logic (master) and the instruction memory (slave).
interface imem_pipelined_if;
  import imem_pipelined_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] pcf;
  logic            stall;
  logic            flush;
  logic            resp_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] resp_pc;
  logic            fault;

  modport master (
    output req_valid, pcf, stall, flush,
    input  req_ready, resp_valid, instr, resp_pc, fault
  );

  modport slave (
    input  req_valid, pcf, stall, flush,
    output req_ready, resp_valid, instr, resp_pc, fault
  );

endinterface

// File: rtl/imem_pipelined_array.sv
// Synchronous-read instruction RAM; infers block RAM.
// With IMEM_LOAD_PORT_EN defined it gains a write port (read-before-write on address collision).
module imem_pipelined_array #(
  parameter int unsigned DEPTH     = 256,
  parameter string       INIT_FILE = ""
) (
  input  logic                     i_clk,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
`ifdef IMEM_LOAD_PORT_EN
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [31:0]              i_wr_data,
`endif
  output logic [31:0]              o_rd_data
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
`ifdef IMEM_LOAD_PORT_EN
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
`endif
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_pipelined.sv
// Pipelined RV32I instruction memory: fault decode, LATENCY-deep read pipeline, stall/flush control.
// Define IMEM_LOAD_PORT_EN to add a synchronous load port into the array.
module imem_pipelined #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 1,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] NOP_INSTR = imem_pipelined_pkg::NOP_INSTR
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
`ifdef IMEM_LOAD_PORT_EN
  input  logic                     i_load_en,
  input  logic [$clog2(DEPTH)-1:0] i_load_addr,
  input  logic [31:0]              i_load_data,
`endif
  imem_pipelined_if.slave          fetch
);
  import imem_pipelined_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic          w_fault;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic [31:0]   w_rd_data;
  logic          r_v0;
  logic          r_fault0;
  logic          r_loaded;
  logic [31:0]   r_pc0;
  fetch_resp_t   w_s0;
  fetch_resp_t   w_out;

  assign fetch.req_ready = !fetch.stall;

  // Any word-index bit above the array address means out of range
  assign w_fault   = (fetch.pcf[1:0] != 2'b00) || (fetch.pcf[31:AW+2] != '0);
  assign w_rd_en   = fetch.req_valid && !fetch.stall && !fetch.flush && !w_fault;
  assign w_rd_addr = fetch.pcf[AW+1:2];

  imem_pipelined_array #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .i_clk     (i_clk),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
`ifdef IMEM_LOAD_PORT_EN
    .i_wr_en   (i_load_en && i_rst_n),
    .i_wr_addr (i_load_addr),
    .i_wr_data (i_load_data),
`endif
    .o_rd_data (w_rd_data)
  );

  // First stage: sidebands registered alongside the RAM read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v0     <= 1'b0;
      r_pc0    <= '0;
      r_fault0 <= 1'b0;
      r_loaded <= 1'b0;
    end else if (fetch.flush) begin
      r_v0 <= 1'b0;
    end else if (!fetch.stall) begin
      r_v0 <= fetch.req_valid;
      if (fetch.req_valid) begin
        r_pc0    <= fetch.pcf;
        r_fault0 <= w_fault;
        if (!w_fault) r_loaded <= 1'b1;
      end
    end
  end

  // RAM output register has no reset, so mask it until a real read has happened
  always_comb begin
    w_s0.valid = r_v0;
    w_s0.pc    = r_pc0;
    w_s0.fault = r_fault0;
    w_s0.instr = r_fault0 ? NOP_INSTR : (r_loaded ? w_rd_data : '0);
  end

  if (LATENCY == 1) begin : g_direct
    assign w_out = w_s0;
  end else begin : g_pipe
    fetch_resp_t [LATENCY-2:0] r_pipe;
    fetch_resp_t [LATENCY-2:0] w_in;

    always_comb begin
      w_in    = '0;
      w_in[0] = w_s0;
      for (int unsigned i = 1; i < LATENCY - 1; i++) w_in[i] = r_pipe[i-1];
    end

    // Payload only moves with a valid beat, so outputs hold while resp_valid is low
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_pipe <= '0;
      end else if (fetch.flush) begin
        for (int unsigned i = 0; i < LATENCY - 1; i++) r_pipe[i].valid <= 1'b0;
      end else if (!fetch.stall) begin
        for (int unsigned i = 0; i < LATENCY - 1; i++) begin
          r_pipe[i].valid <= w_in[i].valid;
          if (w_in[i].valid) begin
            r_pipe[i].pc    <= w_in[i].pc;
            r_pipe[i].instr <= w_in[i].instr;
            r_pipe[i].fault <= w_in[i].fault;
          end
        end
      end
    end

    assign w_out = r_pipe[LATENCY-2];
  end

  assign fetch.resp_valid = w_out.valid;
  assign fetch.instr      = w_out.instr;
  assign fetch.resp_pc    = w_out.pc;
  assign fetch.fault      = w_out.fault;

endmodule

// File: tb/tb_imem_pipelined.sv
// Randomised scoreboard bench for imem_pipelined (DEPTH=64, LATENCY=3); IMEM_LOAD_PORT_EN aware.
module tb_imem_pipelined;
  import imem_pipelined_pkg::*;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned AW      = 6;
  localparam logic [31:0] W0      = 32'h0145_0513;
  localparam logic [31:0] W1      = 32'h0149_8933;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_pipelined_if fetch ();

`ifdef IMEM_LOAD_PORT_EN
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
`endif

  imem_pipelined #(
    .DEPTH     (DEPTH),
    .LATENCY   (LATENCY),
    .INIT_FILE (""),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
`ifdef IMEM_LOAD_PORT_EN
    .i_load_en   (load_en),
    .i_load_addr (load_addr),
    .i_load_data (load_data),
`endif
    .fetch       (fetch)
  );

  logic [31:0] mem_model [DEPTH];
  exp_t        sb [$];
  int unsigned adv = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_instr = '0;
  logic [31:0] last_pc = '0;
  logic        last_fault = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || ((pc >> 2) >= DEPTH);
  endfunction

  // Reference model: every accepted fetch is due LATENCY unstalled edges after acceptance
  always @(posedge clk) begin
    if (rst_n) begin
      if (fetch.flush) begin
        sb.delete();
      end else if (!fetch.stall) begin
        adv <= adv + 1;
        if (fetch.req_valid)
          sb.push_back('{pc: fetch.pcf,
                         instr: exp_fault(fetch.pcf) ? NOP_INSTR : mem_model[fetch.pcf[AW+1:2]],
                         fault: exp_fault(fetch.pcf),
                         due: adv + LATENCY});
      end
`ifdef IMEM_LOAD_PORT_EN
      if (load_en) mem_model[load_addr] <= load_data;
`endif
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last_instr <= '0;
      last_pc    <= '0;
      last_fault <= 1'b0;
    end else begin
      check("req_ready", 32'(fetch.req_ready), 32'(!fetch.stall));
      if (fetch.resp_valid) begin
        check("resp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("resp_pc", fetch.resp_pc, sb[0].pc);
          check("instr", fetch.instr, sb[0].instr);
          check("fault", 32'(fetch.fault), 32'(sb[0].fault));
          check("latency", adv, sb[0].due);
          if (!fetch.stall && !fetch.flush) void'(sb.pop_front());
        end
        last_instr <= fetch.instr;
        last_pc    <= fetch.resp_pc;
        last_fault <= fetch.fault;
      end else begin
        check("held_instr", fetch.instr, last_instr);
        check("held_pc", fetch.resp_pc, last_pc);
        check("held_fault", 32'(fetch.fault), 32'(last_fault));
        if (sb.size() != 0) check("resp_on_time", 32'(sb[0].due > adv), 32'd1);
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc, input logic st, input logic fl);
    fetch.req_valid = v;
    fetch.pcf       = pc;
    fetch.stall     = st;
    fetch.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic random_phase(input int n);
    logic [31:0] pc;
    int          sel;
    for (int k = 0; k < n; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      pc = $urandom;
      else if (sel == 1) pc = $urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3);
      else               pc = $urandom_range(0, DEPTH - 1) * 4;
      cyc($urandom_range(0, 99) < 80, pc, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
    end
  endtask

  initial begin
    rst_n           = 1'b1;
    fetch.req_valid = 1'b0;
    fetch.pcf       = '0;
    fetch.stall     = 1'b0;
    fetch.flush     = 1'b0;
    #1 rst_n = 1'b0;
`ifndef IMEM_LOAD_PORT_EN
    #1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_model[i] = (i == 0) ? W0 : (i == 1) ? W1 : $urandom;
      dut.u_array.r_mem[i] = mem_model[i];
    end
`endif
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(fetch.resp_valid), 32'd0);
    check("rst_instr", fetch.instr, 32'd0);
    check("rst_pc", fetch.resp_pc, 32'd0);
    check("rst_fault", 32'(fetch.fault), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef IMEM_LOAD_PORT_EN
    for (int i = 0; i < int'(DEPTH); i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = (i == 0) ? W0 : (i == 1) ? W1 : $urandom;
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;
`endif
    // Basic fetch, back-to-back, then a stall while a response is being presented
    cyc(1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h4, 1'b0, 1'b0);
    idle(4);
    cyc(1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h4, 1'b0, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 1'b0);
    idle(4);
    cyc(1'b1, 32'h10, 1'b0, 1'b0);
    cyc(1'b1, 32'h14, 1'b0, 1'b0);
    cyc(1'b1, 32'h18, 1'b0, 1'b0);
    cyc(1'b1, 32'h1c, 1'b1, 1'b0);
    cyc(1'b1, 32'h1c, 1'b1, 1'b0);
    cyc(1'b1, 32'h1c, 1'b0, 1'b0);
    idle(5);
    // Flush with two in flight, then flush and stall together
    cyc(1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h4, 1'b0, 1'b0);
    cyc(1'b1, 32'h30, 1'b0, 1'b1);
    check("flush_valid", 32'(fetch.resp_valid), 32'd0);
    cyc(1'b1, 32'h20, 1'b0, 1'b0);
    idle(4);
    cyc(1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h4, 1'b0, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 1'b0);
    cyc(1'b1, 32'hc, 1'b1, 1'b1);
    check("flush_stall_valid", 32'(fetch.resp_valid), 32'd0);
    idle(4);
    // Faults: misaligned, first out-of-range word, far out of range
    cyc(1'b1, 32'h6, 1'b0, 1'b0);
    cyc(1'b1, DEPTH * 4, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'hc, 1'b0, 1'b0);
    idle(4);
`ifdef IMEM_LOAD_PORT_EN
    load_en   = 1'b1;
    load_addr = AW'(2);
    load_data = 32'h00a5_8593;
    cyc(1'b1, 32'h8, 1'b0, 1'b0);
    load_en = 1'b0;
    cyc(1'b1, 32'h8, 1'b0, 1'b0);
    idle(4);
`endif
    random_phase(400);
    // Asynchronous reset in mid-cycle with fetches in flight
    cyc(1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h4, 1'b0, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(fetch.resp_valid), 32'd0);
    check("arst_instr", fetch.instr, 32'd0);
    check("arst_pc", fetch.resp_pc, 32'd0);
    check("arst_fault", 32'(fetch.fault), 32'd0);
    sb.delete();
    fetch.req_valid = 1'b1;
    fetch.pcf       = 32'h4;
    fetch.stall     = 1'b0;
    fetch.flush     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    random_phase(200);
    for (int n = 0; n < 20 && sb.size() != 0; n++) idle(1);
    check("drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
